param_register_file: RTL and testbench

//   Next-generation register file for the SIWO datapath.
//   - Depth, data width and read-port count are parametrised.
//   - Optional hardwired zero register (r0).
//   - Optional write-to-read bypass (same-cycle forwarding).
//   - Per-register busy scoreboard: a register is reserved at issue and

---
 rtl/param_register_file_if.sv | 30 +++
 rtl/param_register_file.sv | 77 +++++++
 tb/tb_param_register_file.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/param_register_file_if.sv
// Register-file bus: writeback write port, issue reserve port, decode read ports.
interface param_register_file_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic                     _regWrite;
    logic [ADDR_W-1:0]        _regDest;
    logic [DATA_W-1:0]        _writeVal;
    logic                     _reserve;
    logic [ADDR_W-1:0]        _reserveDest;
    logic [NUM_RD*ADDR_W-1:0] _regSrc;
    logic [NUM_RD*DATA_W-1:0] values;
    logic [NUM_RD-1:0]        srcBusy;
    logic [DEPTH-1:0]         busyMask;

    // Decode/writeback side drives indices and data, observes read results.
    modport master (
        output _regWrite, _regDest, _writeVal, _reserve, _reserveDest, _regSrc,
        input  values, srcBusy, busyMask
    );

    // Register file side.
    modport slave (
        input  _regWrite, _regDest, _writeVal, _reserve, _reserveDest, _regSrc,
        output values, srcBusy, busyMask
    );
endinterface

// File: rtl/param_register_file.sv
// Parameterised register file with optional hardwired r0, optional
// write-to-read forwarding and a per-register busy scoreboard.
module param_register_file #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  _CLK,
    input  logic                  _RESET,
    param_register_file_if.slave  rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic                         wr_ok, res_ok;

    // r0 suppression applies to both the write and the reserve port.
    always_comb begin
        wr_ok  = rf._regWrite && !((ZERO_REG != 0) && (rf._regDest == '0));
        res_ok = rf._reserve  && !((ZERO_REG != 0) && (rf._reserveDest == '0));
    end

    // Next-state: writeback clears busy, a reserve in the same cycle re-sets it
    // because it marks a newer producer for that register.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[rf._regDest] = rf._writeVal;
            busy_d[rf._regDest] = 1'b0;
        end
        if (res_ok) begin
            busy_d[rf._reserveDest] = 1'b1;
        end
    end

    // State registers; reset overrides any write or reserve on the same edge.
    always_ff @(posedge _CLK) begin
        if (_RESET) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign rf.busyMask = busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              is_r0;
        logic              fwd;

        assign idx   = rf._regSrc[i*ADDR_W +: ADDR_W];
        assign is_r0 = (ZERO_REG != 0) && (idx == '0);
        // Forward only writes that will actually land on this edge.
        assign fwd   = (BYPASS != 0) && rf._regWrite && !_RESET &&
                       (idx == rf._regDest) && !is_r0;

        // Read mux: hardwired zero, then forwarded data, then stored state.
        always_comb begin
            rf.values[i*DATA_W +: DATA_W] = regs_q[idx];
            rf.srcBusy[i]                 = busy_q[idx];
            if (is_r0) begin
                rf.values[i*DATA_W +: DATA_W] = '0;
                rf.srcBusy[i]                 = 1'b0;
            end else if (fwd) begin
                rf.values[i*DATA_W +: DATA_W] = rf._writeVal;
                rf.srcBusy[i]                 = res_ok && (rf._reserveDest == idx);
            end
        end
    end
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: two instances driven identically,
// A = hardwired r0 + forwarding, B = plain r0 + no forwarding.
module tb_param_register_file;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NUM_RD = 2;

    typedef struct {
        string       tag;
        int          dut;   // 0 = A, 1 = B
        int          kind;  // 0 values, 1 srcBusy, 2 busyMask
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    param_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) if_a ();
    param_register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) if_b ();

    param_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                          .ZERO_REG(1), .BYPASS(1)) u_a (
        ._CLK(clk), ._RESET(rst), .rf(if_a.slave));

    param_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                          .ZERO_REG(0), .BYPASS(0)) u_b (
        ._CLK(clk), ._RESET(rst), .rf(if_b.slave));

    always #5 clk = ~clk;

    task automatic drive(input logic w, input logic [2:0] wd, input logic [7:0] wv,
                         input logic r, input logic [2:0] rd,
                         input logic [2:0] s0, input logic [2:0] s1);
        if_a._regWrite = w; if_a._regDest = wd; if_a._writeVal = wv;
        if_a._reserve = r;  if_a._reserveDest = rd; if_a._regSrc = {s1, s0};
        if_b._regWrite = w; if_b._regDest = wd; if_b._writeVal = wv;
        if_b._reserve = r;  if_b._reserveDest = rd; if_b._regSrc = {s1, s0};
    endtask

    task automatic push(input string tag, input int dut, input int kind,
                        input int port, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.dut = dut; e.kind = kind; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] get_obs(input int dut, input int kind, input int port);
        logic [31:0] o;
        o = '0;
        if (dut == 0) begin
            case (kind)
                0: o[7:0] = if_a.values[port*DATA_W +: DATA_W];
                1: o[0]   = if_a.srcBusy[port];
                default: o[7:0] = if_a.busyMask;
            endcase
        end else begin
            case (kind)
                0: o[7:0] = if_b.values[port*DATA_W +: DATA_W];
                1: o[0]   = if_b.srcBusy[port];
                default: o[7:0] = if_b.busyMask;
            endcase
        end
        return o;
    endfunction

    // Pop every pending expectation and compare with what the DUTs show now.
    task automatic check_pop();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.dut, e.kind, e.port);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s dut%0d: observed=%0h expected=%0h", e.tag, e.dut, obs, e.exp);
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // 1. dirty state, then reset
        drive(1, 3, 8'h5A, 1, 4, 0, 0);
        @(posedge clk); @(negedge clk);
        drive(0, 0, 0, 0, 0, 3, 4);
        #1;
        push("pre_rst_r3", 0, 0, 0, 'h5A); push("pre_rst_r3", 1, 0, 0, 'h5A);
        push("pre_rst_busy4", 0, 1, 1, 1);  push("pre_rst_mask", 1, 2, 0, 'h10);
        check_pop();
        rst = 1'b1;
        @(posedge clk); @(negedge clk); rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            push("rst_val0", d, 0, 0, 0); push("rst_val1", d, 0, 1, 0);
            push("rst_busy0", d, 1, 0, 0); push("rst_busy1", d, 1, 1, 0);
            push("rst_mask", d, 2, 0, 0);
        end
        check_pop();

        // 2. two writes, read both back
        @(negedge clk); drive(1, 2, 8'h07, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk); drive(1, 5, 8'h11, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk); drive(0, 0, 0, 0, 0, 2, 5);
        #1;
        for (int d = 0; d < 2; d++) begin
            push("rd_r2", d, 0, 0, 'h07); push("rd_r5", d, 0, 1, 'h11);
            push("rd_busy", d, 1, 0, 0);
        end
        check_pop();

        // 3. same-cycle forwarding vs none
        @(negedge clk); drive(1, 2, 8'd55, 0, 0, 2, 2);
        #1;
        push("byp_on", 0, 0, 0, 55); push("byp_off", 1, 0, 0, 'h07);
        push("byp_busy", 0, 1, 0, 0); push("byp_dual_port", 0, 0, 1, 55);
        check_pop();
        @(posedge clk); @(negedge clk); drive(0, 0, 0, 0, 0, 2, 2);
        #1;
        for (int d = 0; d < 2; d++) begin
            push("post_wr_p0", d, 0, 0, 55); push("post_wr_p1", d, 0, 1, 55);
        end
        check_pop();

        // 4. write + reserve r0
        @(negedge clk); drive(1, 0, 8'd10, 1, 0, 0, 0);
        #1;
        push("r0_pre_a", 0, 0, 0, 0); push("r0_pre_b", 1, 0, 0, 0);
        check_pop();
        @(posedge clk); @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        push("r0_val_a", 0, 0, 0, 0);  push("r0_mask_a", 0, 2, 0, 'h00);
        push("r0_val_b", 1, 0, 0, 10); push("r0_mask_b", 1, 2, 0, 'h01);
        push("r0_busy_b", 1, 1, 0, 1);
        check_pop();

        // 5. scoreboard on r6
        @(negedge clk); drive(0, 0, 0, 1, 6, 0, 6);
        @(posedge clk); @(negedge clk); drive(0, 0, 0, 0, 0, 0, 6);
        #1;
        push("res6_busy", 0, 1, 1, 1); push("res6_busy", 1, 1, 1, 1);
        push("res6_mask", 0, 2, 0, 'h40); push("res6_mask", 1, 2, 0, 'h41);
        check_pop();
        @(negedge clk); drive(1, 6, 8'd14, 0, 0, 0, 6);
        #1;
        push("wr6_fwd_val", 0, 0, 1, 14); push("wr6_fwd_busy", 0, 1, 1, 0);
        push("wr6_nofwd_val", 1, 0, 1, 0); push("wr6_nofwd_busy", 1, 1, 1, 1);
        check_pop();
        @(posedge clk); @(negedge clk); drive(0, 0, 0, 0, 0, 0, 6);
        #1;
        push("wr6_val", 0, 0, 1, 14); push("wr6_val", 1, 0, 1, 14);
        push("wr6_busy", 0, 1, 1, 0); push("wr6_busy", 1, 1, 1, 0);
        push("wr6_mask", 0, 2, 0, 'h00); push("wr6_mask", 1, 2, 0, 'h01);
        check_pop();
        @(negedge clk); drive(1, 6, 8'd14, 1, 6, 0, 6);
        #1;
        push("wrres6_fwd_busy", 0, 1, 1, 1); push("wrres6_fwd_val", 0, 0, 1, 14);
        check_pop();
        @(posedge clk); @(negedge clk); drive(0, 0, 0, 0, 0, 0, 6);
        #1;
        push("wrres6_val", 0, 0, 1, 14); push("wrres6_val", 1, 0, 1, 14);
        push("wrres6_busy", 0, 1, 1, 1); push("wrres6_busy", 1, 1, 1, 1);
        push("wrres6_mask", 0, 2, 0, 'h40);
        check_pop();
        // write and reserve on different registers
        @(negedge clk); drive(1, 1, 8'h3C, 1, 7, 1, 7);
        @(posedge clk); @(negedge clk); drive(0, 0, 0, 0, 0, 1, 7);
        #1;
        push("split_val", 0, 0, 0, 'h3C); push("split_busy7", 0, 1, 1, 1);
        push("split_mask", 0, 2, 0, 'hC0); push("split_mask", 1, 2, 0, 'hC1);
        check_pop();

        // 6. reset with write + reserve of r1 pending
        @(negedge clk); rst = 1'b1; drive(1, 1, 8'd9, 1, 1, 1, 1);
        #1;
        push("rst_no_fwd", 0, 0, 0, 'h3C);
        check_pop();
        @(posedge clk); @(negedge clk); rst = 1'b0; drive(0, 0, 0, 0, 0, 1, 1);
        #1;
        for (int d = 0; d < 2; d++) begin
            push("rst_r1_val", d, 0, 0, 0); push("rst_r1_busy", d, 1, 0, 0);
            push("rst_r1_mask", d, 2, 0, 0);
        end
        check_pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
